// File: rtl/bcnn_fc_argmax.sv
// bcnn_fc_argmax: binary fully-connected classifier with sequential argmax.
// Consumes one binarized feature bit per accepted cycle. It accumulates one
// XNOR-popcount score per class against a stored weight matrix. After the
// last bit of a frame it scans the class scores one per cycle. It then
// reports the winning class and its score together with a one-cycle done pulse.
// Optional build macro: BCNN_FC_MARGIN_EN adds margin_out (best - second best).
module bcnn_fc_argmax #(
  parameter int NUM_INPUTS  = 121,
  parameter int NUM_CLASSES = 10,
  parameter int ACC_WIDTH   = 7,
  parameter int IDX_WIDTH   = 7,
  parameter int CLS_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic                   bit_in,
  output logic                   in_ready,
  input  logic                   w_wr_en,
  input  logic [IDX_WIDTH-1:0]   w_wr_addr,
  input  logic [NUM_CLASSES-1:0] w_wr_data,
  output logic [CLS_WIDTH-1:0]   class_out,
  output logic [ACC_WIDTH-1:0]   score_out,
  output logic                   done,
  output logic                   drop_err
`ifdef BCNN_FC_MARGIN_EN
  ,
  output logic [ACC_WIDTH-1:0]   margin_out
`endif
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(NUM_INPUTS - 1);
  localparam logic [CLS_WIDTH-1:0] LAST_CLS   = CLS_WIDTH'(NUM_CLASSES - 1);
  localparam logic [IDX_WIDTH:0]   NUM_IN_EXT = (IDX_WIDTH + 1)'(NUM_INPUTS);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, ARGMAX = 2'd2, OUT = 2'd3} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_WIDTH-1:0]   idx_reg;
  logic [CLS_WIDTH-1:0]   cls_reg;
  logic [ACC_WIDTH-1:0]   acc_reg [NUM_CLASSES];
  logic [ACC_WIDTH-1:0]   best_score_reg;
  logic [CLS_WIDTH-1:0]   best_cls_reg;
  logic [NUM_CLASSES-1:0] w_mem [NUM_INPUTS];
  logic [NUM_CLASSES-1:0] w_row;
  logic [NUM_CLASSES-1:0] match;
  logic [ACC_WIDTH-1:0]   cand;
  logic                   accept;
  logic                   first_bit;
  logic                   acc_step;
  logic                   frame_end;

  // Weight column read is combinational on the running index. A write to
  // the same address lands at the edge, so the current bit sees the old column.
  assign w_row = w_mem[idx_reg];
  assign match = ~(w_row ^ {NUM_CLASSES{bit_in}});
  assign cand  = acc_reg[cls_reg];

  // Weight memory: column writes, out-of-range addresses dropped, never reset
  always_ff @(posedge clk) begin
    if (w_wr_en && ({1'b0, w_wr_addr} < NUM_IN_EXT)) begin
      w_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic; a bit accepted in OUT starts the next frame
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, OUT: begin
        if (accept) state_next = frame_end ? ARGMAX : ACCUM;
        else        state_next = IDLE;
      end
      ACCUM:   if (frame_end) state_next = ARGMAX;
      ARGMAX:  if (cls_reg == LAST_CLS) state_next = OUT;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake and per-cycle datapath strobes
  always_comb begin
    in_ready  = (state_reg != ARGMAX);
    accept    = valid_in && in_ready;
    first_bit = accept && ((state_reg == IDLE) || (state_reg == OUT));
    acc_step  = accept && (state_reg == ACCUM);
    frame_end = (acc_step && (idx_reg == LAST_IDX)) || (first_bit && (NUM_INPUTS == 1));
  end

  // Input index: returns to 0 after the last bit so the next frame starts at column 0
  always_ff @(posedge clk) begin
    if (reset)          idx_reg <= '0;
    else if (frame_end) idx_reg <= '0;
    else if (accept)    idx_reg <= idx_reg + IDX_WIDTH'(1);
  end

  // Per-class score accumulators, all classes updated in parallel
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_acc
    always_ff @(posedge clk) begin
      if (reset)          acc_reg[gi] <= '0;
      else if (first_bit) acc_reg[gi] <= {{(ACC_WIDTH-1){1'b0}}, match[gi]};
      else if (acc_step)  acc_reg[gi] <= acc_reg[gi] + {{(ACC_WIDTH-1){1'b0}}, match[gi]};
    end
  end

  // Sequential argmax: strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (reset) begin
      cls_reg        <= '0;
      best_score_reg <= '0;
      best_cls_reg   <= '0;
    end else if (state_reg == ARGMAX) begin
      cls_reg <= (cls_reg == LAST_CLS) ? '0 : cls_reg + CLS_WIDTH'(1);
      if (cls_reg == '0) begin
        best_score_reg <= cand;
        best_cls_reg   <= '0;
      end else if (cand > best_score_reg) begin
        best_score_reg <= cand;
        best_cls_reg   <= cls_reg;
      end
    end
  end

`ifdef BCNN_FC_MARGIN_EN
  logic [ACC_WIDTH-1:0] second_reg;

  // Runner-up tracking; a tie with the best falls through and sets second = best
  always_ff @(posedge clk) begin
    if (reset) begin
      second_reg <= '0;
    end else if (state_reg == ARGMAX) begin
      if (cls_reg == '0)               second_reg <= '0;
      else if (cand > best_score_reg)  second_reg <= best_score_reg;
      else if (cand > second_reg)      second_reg <= cand;
    end
  end

  // Margin output, updated together with the result
  always_ff @(posedge clk) begin
    if (reset)                  margin_out <= '0;
    else if (state_reg == OUT)  margin_out <= best_score_reg - second_reg;
  end
`endif

  // Result registers and done pulse, loaded on the OUT cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      class_out <= '0;
      score_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state_reg == OUT);
      if (state_reg == OUT) begin
        class_out <= best_cls_reg;
        score_out <= best_score_reg;
      end
    end
  end

  // Sticky flag for bits offered while the scan is running
  always_ff @(posedge clk) begin
    if (reset)                      drop_err <= 1'b0;
    else if (valid_in && !in_ready) drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_bcnn_fc_argmax.sv
// Testbench for bcnn_fc_argmax: random and directed frames checked against a
// score/argmax reference model. Honors BCNN_FC_MARGIN_EN like the design.
module tb_bcnn_fc_argmax;
  localparam int NI = 121;
  localparam int NC = 10;
  localparam int AW = 7;
  localparam int IW = 7;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in = 1'b0;
  logic          bit_in = 1'b0;
  logic          in_ready;
  logic          w_wr_en = 1'b0;
  logic [IW-1:0] w_wr_addr = '0;
  logic [NC-1:0] w_wr_data = '0;
  logic [CW-1:0] class_out;
  logic [AW-1:0] score_out;
  logic          done;
  logic          drop_err;
`ifdef BCNN_FC_MARGIN_EN
  logic [AW-1:0] margin_out;
`endif

  always #5 clk = ~clk;

  bcnn_fc_argmax dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .bit_in    (bit_in),
    .in_ready  (in_ready),
    .w_wr_en   (w_wr_en),
    .w_wr_addr (w_wr_addr),
    .w_wr_data (w_wr_data),
    .class_out (class_out),
    .score_out (score_out),
    .done      (done),
    .drop_err  (drop_err)
`ifdef BCNN_FC_MARGIN_EN
    ,
    .margin_out(margin_out)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  logic [NC-1:0] wm [NI];
  int sc [NC];
  typedef struct {int cls; int score; int margin; int at;} res_t;
  res_t expq[$];
  res_t e;
  int held_cls = 0;
  int held_score = 0;
  int held_margin = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (done) begin
      if (expq.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("class", int'(class_out), e.cls);
        chk("score", int'(score_out), e.score);
`ifdef BCNN_FC_MARGIN_EN
        chk("margin", int'(margin_out), e.margin);
`endif
        $display("frame done at cycle %0d: class=%0d score=%0d", cyc, class_out, score_out);
        held_cls = e.cls;
        held_score = e.score;
        held_margin = e.margin;
      end
    end else if (!reset) begin
      chk("held_class", int'(class_out), held_cls);
      chk("held_score", int'(score_out), held_score);
`ifdef BCNN_FC_MARGIN_EN
      chk("held_margin", int'(margin_out), held_margin);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    bit_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic write_w(input int a, input logic [NC-1:0] d);
    w_wr_en = 1'b1;
    w_wr_addr = a[IW-1:0];
    w_wr_data = d;
    tick();
    w_wr_en = 1'b0;
    if (a < NI) wm[a] = d;
  endtask

  // mode 0: random, 1: only class 3 ones, 2: all zero
  task automatic load_w(input int mode);
    logic [NC-1:0] d;
    for (int i = 0; i < NI; i++) begin
      if (mode == 1) d = NC'(1 << 3);
      else if (mode == 2) d = '0;
      else d = NC'($urandom);
      write_w(i, d);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    tick();
    reset = 1'b0;
    held_cls = 0;
    held_score = 0;
    held_margin = 0;
    chk("rst_class", int'(class_out), 0);
    chk("rst_score", int'(score_out), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_drop_err", int'(drop_err), 0);
    chk("rst_in_ready", int'(in_ready), 1);
`ifdef BCNN_FC_MARGIN_EN
    chk("rst_margin", int'(margin_out), 0);
`endif
  endtask

  // Stream one frame; the model scores each bit against the weights in force
  // before any same-cycle write, then queues the expected result.
  task automatic send_frame(input logic [NI-1:0] bits, input int wr_at,
                            input logic [NC-1:0] wr_data, input bit gaps);
    int best_c;
    int second;
    res_t r;
    for (int c = 0; c < NC; c++) sc[c] = 0;
    for (int i = 0; i < NI; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 7) == 0) idle(1);
      chk("in_ready", int'(in_ready), 1);
      valid_in = 1'b1;
      bit_in = bits[i];
      for (int c = 0; c < NC; c++) if (bits[i] == wm[i][c]) sc[c]++;
      if (i == wr_at) begin
        w_wr_en = 1'b1;
        w_wr_addr = IW'(i);
        w_wr_data = wr_data;
      end
      tick();
      if (i == wr_at) begin
        w_wr_en = 1'b0;
        wm[i] = wr_data;
      end
    end
    valid_in = 1'b0;
    best_c = 0;
    for (int c = 1; c < NC; c++) if (sc[c] > sc[best_c]) best_c = c;
    second = 0;
    for (int c = 0; c < NC; c++) if (c != best_c && sc[c] > second) second = sc[c];
    r.cls = best_c;
    r.score = sc[best_c];
    r.margin = sc[best_c] - second;
    r.at = cyc + NC + 1;
    expq.push_back(r);
  endtask

  logic [NI-1:0] bits;
  logic [NI-1:0] pat;
  logic [NC-1:0] d;

  initial begin
    idle(2);
    do_reset();

    // Class 3 all ones, stream of ones
    load_w(1);
    send_frame({NI{1'b1}}, -1, '0, 1'b0);
    idle(NC + 3);

    // All-zero weights and input: full tie, lowest index wins
    load_w(2);
    send_frame({NI{1'b0}}, -1, '0, 1'b0);
    idle(NC + 3);

    // Class 2 matches bits 0..99, class 7 matches 0..59, others never
    for (int i = 0; i < NI; i++) pat[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < NI; i++) begin
      d = {NC{~pat[i]}};
      d[2] = (i < 100) ? pat[i] : ~pat[i];
      d[7] = (i < 60) ? pat[i] : ~pat[i];
      write_w(i, d);
    end
    send_frame(pat, -1, '0, 1'b0);
    idle(NC + 3);

    // Random frames; odd frames start in the OUT cycle of the previous one
    for (int f = 0; f < 50; f++) begin
      if (f % 10 == 0) load_w(0);
      if ($urandom_range(0, 2) == 0) write_w(NI + $urandom_range(0, 6), NC'($urandom));
      for (int i = 0; i < NI; i++) bits[i] = 1'($urandom_range(0, 1));
      send_frame(bits, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NI - 1) : -1,
                 NC'($urandom), f[2]);
      if (f % 2 == 1) idle(NC);
      else idle(NC + $urandom_range(2, 5));
    end
    idle(3);

    // Write to address 5 in the cycle its bit is consumed, then reuse
    for (int i = 0; i < NI; i++) bits[i] = 1'($urandom_range(0, 1));
    send_frame(bits, 5, ~wm[5], 1'b0);
    idle(NC);
    send_frame(bits, -1, '0, 1'b0);
    idle(NC + 3);

    // Reset after 50 accepted bits abandons the frame; weights survive
    for (int i = 0; i < 50; i++) begin
      valid_in = 1'b1;
      bit_in = 1'($urandom_range(0, 1));
      tick();
    end
    do_reset();
    send_frame(bits, -1, '0, 1'b0);
    idle(NC + 3);
    chk("drop_err_clean", int'(drop_err), 0);

    // Bits offered during the scan are dropped and flagged
    send_frame(bits, -1, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("busy_in_ready", int'(in_ready), 0);
      valid_in = 1'b1;
      bit_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    chk("drop_err_set", int'(drop_err), 1);
    idle(NC + 5);
    chk("drop_err_sticky", int'(drop_err), 1);

    chk("pending_results", expq.size(), 0);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
